ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. It takes the decoded operands and control fields held by the ID/EX pipeline register and resolves operand forwarding. It computes ALU and shift results and runs an iterative multiply/divide unit with HI/LO registers. Results are registered into the EX/MEM boundary, and `stall_o` is raised when an instruction must wait on the multiply/divide unit.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports (all ports are listed):
- `clk`  in  1  clock; reset `rst`, synchronous, active-high.
- `rst`  in  1  synchronous active-high reset.
- `w_in`  in  2  writeback control: [1] RegWrite, [0] MemtoReg.
- `m_in`  in  2  memory control: [1] MemRead, [0] MemWrite.
- `e_in`  in  4  execute control: [3] RegDst, [2] ALUSrc, [1:0] ALUOp (00 add, 01 sub, 10 R-type by funct, 11 slt).
- `rd1_in`, `rd2_in`  in  32 each  register file read data for rs and rt.
- `funct_in`  in  6  R-type function field.
- `shamt_in`  in  5  shift amount.
- `immed_in`  in  32  sign-extended immediate.
- `rs_in`, `rt_in`, `rd_in`  in  5 each  register numbers.
- `wb_regwrite_in`  in  1  MEM/WB RegWrite.
- `wb_dst_in`  in  5  MEM/WB destination register.
- `wb_data_in`  in  32  MEM/WB writeback value.
- `w_out`, `m_out`  out  2 each  registered control for MEM and WB.
- `alu_out`  out  32  registered result.
- `store_out`  out  32  registered forwarded rt value, used as store data.
- `dst_out`  out  5  registered destination register.
- `stall_o`  out  1  combinational; upstream holds PC, IF/ID and ID/EX while it is high.

## Operation
- **Forwarding, operand A (rs):**
  - Use the EX/MEM value if `w_out[1]`, `!m_out[1]`, `dst_out!=0` and `dst_out==rs_in`.
  - Otherwise use MEM/WB if `wb_regwrite_in`, `wb_dst_in!=0` and `wb_dst_in==rs_in`.
  - Otherwise use `rd1_in`.
- **Forwarding, operand B (rt):** same rule against `rt_in` and `rd2_in`.
- **ALU operand B:** `immed_in` if ALUSrc, else forwarded rt.
- **Destination:** `rd_in` if RegDst, else `rt_in`.
- **R-type functions:**
  - add/addu 0x20/0x21, sub/subu 0x22/0x23: arithmetic wraps modulo 2^32; no overflow trap.
  - and 0x24, or 0x25, xor 0x26, nor 0x27.
  - slt 0x2A signed, sltu 0x2B unsigned; result is 0 or 1.
  - sll 0x00, srl 0x02, sra 0x03 shift forwarded rt by `shamt_in`.
  - mult 0x18, multu 0x19, div 0x1A, divu 0x1B start the unit.
  - mfhi 0x10, mflo 0x12 return HI or LO.
  - Undefined funct yields 0.
- **Multiply/divide unit:**
  - States: IDLE, MUL, DIV. A 5-bit iteration counter runs 0 to 31.
  - A mult/div in EX with the unit IDLE is accepted at that edge: magnitudes and signs are captured and the FSM enters MUL or DIV.
  - Multiply is shift-add; divide is restoring. Both run on magnitudes. Signed results are fixed up on the final iteration:
    - product and quotient are negated when the operand signs differ;
    - the remainder takes the sign of the dividend.
  - On the 32nd iteration edge, HI/LO are written and the FSM returns to IDLE.
  - Divide by zero, signed or unsigned: LO=0xFFFFFFFF and HI=the rs operand.
  - mult/div force `w_out=0` and `m_out=0`.
- **Stall:** `stall_o` = busy AND (EX instruction is mult, div, mfhi or mflo). While `stall_o` is high:
  - EX/MEM captures a bubble: `w_out=0`, `m_out=0`, `alu_out=0`, `dst_out=0`;
  - a waiting mult/div is not accepted.
- **Reset:** every output and HI, LO and the counter clear to 0; FSM goes to IDLE. Reset mid-operation abandons the operation and leaves HI/LO at 0.

## Timing
- ALU, shift and mfhi/mflo results: 1 cycle latency, registered at the edge that ends the instruction's EX cycle.
- Mult/div accepted at edge E0: busy is high in cycles E0+ through E32; HI/LO update at E32.
- An mfhi issued directly after mult stalls exactly 32 cycles, then completes at the following edge.
- Load-use hazards are resolved upstream. EX/MEM load results are never forwarded.

## Configuration
- `EX_MULDIV_EN` defined: multiply/divide unit, HI/LO and stall logic are present.
- `EX_MULDIV_EN` undefined:
  - mult/div/mfhi/mflo produce result 0 with `w_out=0`;
  - `stall_o` is tied to 0;
  - no FSM, counter or HI/LO registers are built.

## Structure
- Shared package `ex_pkg`: funct code constants, ALUOp encoding, control bit positions, FSM state enum.
- Sub-module `ex_muldiv`: FSM, counter, HI/LO and the busy output. The top level holds forwarding, ALU and the EX/MEM register.

## Test plan
- **Forwarding:** add r3=r1+r2 with r1=5, r2=7, then sub r4=r3-r1 back to back. Expect r4 result 7, taken via EX/MEM forwarding.
- **Register 0:** MEM/WB writing r0=0x55 while EX reads r0. Expect `rd1_in` used and no forwarding.
- **Signed multiply:** mult with rs=-3, rt=7, then mfhi. Expect `stall_o` high for 32 cycles, then HI=0xFFFFFFFF; mflo then gives 0xFFFFFFEB.
- **Signed divide:** div with rs=-7, rt=2. Expect LO=0xFFFFFFFD and HI=0xFFFFFFFF.
- **Divide by zero:** divu with rs=9, rt=0. Expect LO=0xFFFFFFFF and HI=9.
- **Reset mid-operation:** rst at iteration 10 of a mult. Expect FSM IDLE, HI=LO=0, `stall_o`=0, and all outputs 0 on the next edge.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: funct codes, ALUOp encoding,
// control bit positions and the multiply/divide FSM states.
package ex_pkg;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  // control bit positions
  localparam int E_REGDST   = 3;
  localparam int E_ALUSRC   = 2;
  localparam int W_REGWRITE = 1;
  localparam int M_MEMREAD  = 1;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_t;

  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic is_mf_funct(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO);
  endfunction

  // magnitude of a 32-bit operand, two's complement only when signed
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO. Shift-add multiply and
// restoring divide over 32 iterations on operand magnitudes; sign fixup
// is folded into the final HI/LO write.
module ex_muldiv
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_div,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  md_state_t   state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_nxt;      // mul: {partial, multiplier}; div: {rem, quotient}
  logic [31:0] opd;               // multiplicand or divisor magnitude
  logic        neg_q, neg_r, bzero;
  logic [32:0] mul_sum, div_shift;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] prod;
  logic [31:0] q_fix, r_fix;

  assign busy = (state != MD_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nxt;
  end

  // next state: leave IDLE on an accepted start, return after iteration 31
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = is_div ? MD_DIV : MD_MUL;
      MD_MUL,
      MD_DIV:  if (cnt == 5'd31) state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // one iteration of each algorithm plus final signed fixup
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_ge    = div_shift >= {1'b0, opd};
    div_sub   = div_shift[31:0] - opd;
    if (state == MD_DIV)
      acc_nxt = div_ge ? {div_sub, acc[30:0], 1'b1}
                       : {div_shift[31:0], acc[30:0], 1'b0};
    else
      acc_nxt = {mul_sum, acc[31:1]};
    prod  = neg_q ? -acc_nxt : acc_nxt;
    q_fix = bzero ? 32'hFFFF_FFFF : (neg_q ? -acc_nxt[31:0] : acc_nxt[31:0]);
    r_fix = neg_r ? -acc_nxt[63:32] : acc_nxt[63:32];
  end

  // operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; acc <= '0; opd <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; bzero <= 1'b0;
      hi <= '0; lo <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          cnt   <= '0;
          acc   <= {32'd0, is_div ? mag(a, is_signed) : mag(b, is_signed)};
          opd   <= is_div ? mag(b, is_signed) : mag(a, is_signed);
          neg_q <= is_signed & (a[31] ^ b[31]);
          neg_r <= is_signed & a[31];
          bzero <= (b == 32'd0);
        end
        MD_MUL, MD_DIV: begin
          acc <= acc_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (state == MD_DIV) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod[63:32];
              lo <= prod[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/shifter, EX/MEM register and the
// multiply/divide stall. Define EX_MULDIV_EN to build the mul/div unit with
// HI/LO; without it mult/div/mfhi/mflo retire as non-writing zeros.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      w_in,
  input  logic [1:0]      m_in,
  input  logic [3:0]      e_in,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [5:0]      funct_in,
  input  logic [4:0]      shamt_in,
  input  logic [XLEN-1:0] immed_in,
  input  logic [4:0]      rs_in,
  input  logic [4:0]      rt_in,
  input  logic [4:0]      rd_in,
  input  logic            wb_regwrite_in,
  input  logic [4:0]      wb_dst_in,
  input  logic [XLEN-1:0] wb_data_in,
  output logic [1:0]      w_out,
  output logic [1:0]      m_out,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] store_out,
  output logic [4:0]      dst_out,
  output logic            stall_o
);

  logic [XLEN-1:0] fwd_a, fwd_b, opb, result, hi, lo;
  logic [4:0]      dst;
  logic            rtype, is_md, is_mf, kill, busy;
  logic            exm_ok, exm_a, exm_b, wb_a, wb_b;

  assign rtype = (e_in[1:0] == ALU_RTYPE);
  assign is_md = rtype && is_md_funct(funct_in);
  assign is_mf = rtype && is_mf_funct(funct_in);

`ifdef EX_MULDIV_EN
  ex_muldiv u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (is_md && !busy),
    .is_div    (funct_in == F_DIV || funct_in == F_DIVU),
    .is_signed (funct_in == F_MULT || funct_in == F_DIV),
    .a         (fwd_a),
    .b         (fwd_b),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );
  assign kill    = is_md;
  assign stall_o = busy && (is_md || is_mf);
`else
  assign hi      = '0;
  assign lo      = '0;
  assign busy    = 1'b0;
  assign kill    = is_md || is_mf;
  assign stall_o = busy;
`endif

  // EX/MEM forwards only non-load results; MEM/WB is the fallback
  assign exm_ok = w_out[W_REGWRITE] && !m_out[M_MEMREAD] && (dst_out != 5'd0);
  assign exm_a  = exm_ok && (dst_out == rs_in);
  assign exm_b  = exm_ok && (dst_out == rt_in);
  assign wb_a   = wb_regwrite_in && (wb_dst_in != 5'd0) && (wb_dst_in == rs_in);
  assign wb_b   = wb_regwrite_in && (wb_dst_in != 5'd0) && (wb_dst_in == rt_in);

  // operand selection and ALU/shift result
  always_comb begin
    fwd_a = exm_a ? alu_out : (wb_a ? wb_data_in : rd1_in);
    fwd_b = exm_b ? alu_out : (wb_b ? wb_data_in : rd2_in);
    opb   = e_in[E_ALUSRC] ? immed_in : fwd_b;
    dst   = e_in[E_REGDST] ? rd_in : rt_in;
    result = '0;
    case (e_in[1:0])
      ALU_ADD: result = fwd_a + opb;
      ALU_SUB: result = fwd_a - opb;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(opb)};
      default: begin
        case (funct_in)
          F_ADD, F_ADDU: result = fwd_a + opb;
          F_SUB, F_SUBU: result = fwd_a - opb;
          F_AND:  result = fwd_a & opb;
          F_OR:   result = fwd_a | opb;
          F_XOR:  result = fwd_a ^ opb;
          F_NOR:  result = ~(fwd_a | opb);
          F_SLT:  result = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(opb)};
          F_SLTU: result = {{(XLEN-1){1'b0}}, fwd_a < opb};
          F_SLL:  result = fwd_b << shamt_in;
          F_SRL:  result = fwd_b >> shamt_in;
          F_SRA:  result = $unsigned($signed(fwd_b) >>> shamt_in);
          F_MFHI: result = hi;
          F_MFLO: result = lo;
          default: result = '0;
        endcase
      end
    endcase
  end

  // EX/MEM register; a stall inserts a bubble
  always_ff @(posedge clk) begin
    if (rst || stall_o) begin
      w_out <= '0; m_out <= '0; alu_out <= '0; store_out <= '0; dst_out <= '0;
    end else begin
      w_out     <= kill ? 2'b00 : w_in;
      m_out     <= kill ? 2'b00 : m_in;
      alu_out   <= kill ? '0 : result;
      store_out <= fwd_b;
      dst_out   <= dst;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU vectors, and either the
// mul/div unit (EX_MULDIV_EN) or its disabled behaviour.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  w_in, m_in, w_out, m_out;
  logic [3:0]  e_in;
  logic [31:0] rd1_in, rd2_in, immed_in, wb_data_in, alu_out, store_out;
  logic [5:0]  funct_in;
  logic [4:0]  shamt_in, rs_in, rt_in, rd_in, wb_dst_in, dst_out;
  logic        wb_regwrite_in, stall_o;

  int n_cmp = 0, n_bad = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .w_in(w_in), .m_in(m_in), .e_in(e_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .funct_in(funct_in), .shamt_in(shamt_in),
    .immed_in(immed_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .wb_regwrite_in(wb_regwrite_in), .wb_dst_in(wb_dst_in), .wb_data_in(wb_data_in),
    .w_out(w_out), .m_out(m_out), .alu_out(alu_out), .store_out(store_out),
    .dst_out(dst_out), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rtype(input logic [5:0] f, input logic [4:0] s, t, d,
                       input logic [31:0] a, b, input logic [4:0] sh);
    e_in = 4'b1010; w_in = 2'b10; m_in = 2'b00; funct_in = f;
    rs_in = s; rt_in = t; rd_in = d; rd1_in = a; rd2_in = b;
    shamt_in = sh; immed_in = 32'd0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w"}, w_out, 2'b00);
    chk({tag, "_m"}, m_out, 2'b00);
    chk({tag, "_alu"}, alu_out, 0);
    chk({tag, "_st"}, store_out, 0);
    chk({tag, "_dst"}, dst_out, 0);
    chk({tag, "_stall"}, stall_o, 1'b0);
  endtask

`ifdef EX_MULDIV_EN
  // issue a mul/div then mfhi/mflo; mfhi must stall exactly 32 cycles
  task automatic md_run(input string tag, input logic [5:0] f, input logic [31:0] a, b,
                        input logic [31:0] exp_hi, exp_lo);
    int n;
    rtype(f, 5'd1, 5'd2, 5'd0, a, b, 5'd0);
    chk({tag, "_nostall"}, stall_o, 1'b0);
    step();
    chk({tag, "_wkill"}, w_out, 2'b00);
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 5'd0);
    n = 0;
    while (stall_o && n < 40) begin
      n++;
      step();
      if (n == 1) begin
        chk({tag, "_bub_w"}, w_out, 2'b00);
        chk({tag, "_bub_dst"}, dst_out, 5'd0);
      end
    end
    chk({tag, "_stalls"}, n, 32);
    step();
    chk({tag, "_hi"}, alu_out, exp_hi);
    chk({tag, "_hi_w"}, w_out, 2'b10);
    rtype(F_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 5'd0);
    chk({tag, "_lo_nostall"}, stall_o, 1'b0);
    step();
    chk({tag, "_lo"}, alu_out, exp_lo);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{F_ADD,  32'hFFFFFFFF, 32'h2,        5'd0, 32'h1};
    vecs[1]  = '{F_ADDU, 32'h7FFFFFFF, 32'h1,        5'd0, 32'h80000000};
    vecs[2]  = '{F_SUB,  32'h3,        32'h5,        5'd0, 32'hFFFFFFFE};
    vecs[3]  = '{F_SUBU, 32'h10,       32'h1,        5'd0, 32'hF};
    vecs[4]  = '{F_AND,  32'hF0F0,     32'hFF00,     5'd0, 32'hF000};
    vecs[5]  = '{F_OR,   32'hF0F0,     32'hFF00,     5'd0, 32'hFFF0};
    vecs[6]  = '{F_XOR,  32'hF0F0,     32'hFF00,     5'd0, 32'h0FF0};
    vecs[7]  = '{F_NOR,  32'hF0F0,     32'hFF00,     5'd0, 32'hFFFF000F};
    vecs[8]  = '{F_SLT,  32'hFFFFFFFF, 32'h1,        5'd0, 32'h1};
    vecs[9]  = '{F_SLTU, 32'hFFFFFFFF, 32'h1,        5'd0, 32'h0};
    vecs[10] = '{F_SLL,  32'h0,        32'h1,        5'd4, 32'h10};
    vecs[11] = '{F_SRL,  32'h0,        32'h80000000, 5'd4, 32'h08000000};
    vecs[12] = '{F_SRA,  32'h0,        32'h80000000, 5'd4, 32'hF8000000};
    vecs[13] = '{6'h3F,  32'h1234,     32'h5678,     5'd0, 32'h0};

    wb_regwrite_in = 1'b0; wb_dst_in = 5'd0; wb_data_in = 32'd0;
    rtype(F_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    step(); step();
    chk_zero("reset");
    rst = 1'b0;

    // back-to-back dependency through EX/MEM
    rtype(F_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    step();
    chk("add_res", alu_out, 32'd12);
    chk("add_dst", dst_out, 5'd3);
    chk("add_w", w_out, 2'b10);
    rtype(F_SUB, 5'd3, 5'd1, 5'd4, 32'h99, 32'd5, 5'd0);
    step();
    chk("fwd_exmem", alu_out, 32'd7);
    chk("store", store_out, 32'd5);

    // r0 is never forwarded
    wb_regwrite_in = 1'b1; wb_dst_in = 5'd0; wb_data_in = 32'h55;
    rtype(F_ADD, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 5'd0);
    step();
    chk("r0_nofwd", alu_out, 32'd0);
    // MEM/WB forwarding, then EX/MEM priority over MEM/WB
    wb_dst_in = 5'd5;
    rtype(F_ADD, 5'd5, 5'd6, 5'd10, 32'd1, 32'd2, 5'd0);
    step();
    chk("fwd_memwb", alu_out, 32'h57);
    wb_dst_in = 5'd10;
    rtype(F_ADD, 5'd10, 5'd0, 5'd11, 32'd1, 32'd0, 5'd0);
    step();
    chk("fwd_prio", alu_out, 32'h57);
    wb_regwrite_in = 1'b0;

    // load in EX/MEM is not forwarded
    rtype(F_ADD, 5'd12, 5'd6, 5'd0, 32'h100, 32'd0, 5'd0);
    e_in = 4'b0100; w_in = 2'b11; m_in = 2'b10; immed_in = 32'd4;
    step();
    chk("lw_addr", alu_out, 32'h104);
    chk("lw_dst", dst_out, 5'd6);
    chk("lw_m", m_out, 2'b10);
    rtype(F_ADD, 5'd6, 5'd0, 5'd13, 32'd7, 32'd0, 5'd0);
    step();
    chk("no_load_fwd", alu_out, 32'd7);

    // R-type vectors
    for (int i = 0; i < 14; i++) begin
      rtype(vecs[i].f, 5'd1, 5'd2, 5'd20, vecs[i].a, vecs[i].b, vecs[i].sh);
      step();
      chk($sformatf("vec%0d_f%0h", i, vecs[i].f), alu_out, vecs[i].exp);
    end

    // immediate forms with RegDst=0
    rtype(F_ADD, 5'd1, 5'd7, 5'd21, 32'd10, 32'd0, 5'd0);
    e_in = 4'b0101; immed_in = 32'd3;
    step();
    chk("subi", alu_out, 32'd7);
    chk("subi_dst", dst_out, 5'd7);
    rtype(F_ADD, 5'd1, 5'd2, 5'd21, 32'hFFFFFFFE, 32'd0, 5'd0);
    e_in = 4'b0111; immed_in = 32'hFFFFFFFF;
    step();
    chk("slti", alu_out, 32'd1);

`ifdef EX_MULDIV_EN
    md_run("mult", F_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_run("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE);
    md_run("div", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("divu0", F_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);

    // reset ten iterations into a mult
    rtype(F_MULT, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 5'd0);
    step();
    rtype(F_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    for (int i = 0; i < 10; i++) step();
    rtype(F_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 5'd0);
    rst = 1'b1;
    step();
    chk_zero("rst_mid");
    rst = 1'b0;
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 5'd0);
    chk("rst_idle", stall_o, 1'b0);
    step();
    chk("rst_hi", alu_out, 32'd0);
    rtype(F_MFLO, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 5'd0);
    step();
    chk("rst_lo", alu_out, 32'd0);
`else
    rtype(F_MULT, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 5'd0);
    chk("dis_mult_stall", stall_o, 1'b0);
    step();
    chk("dis_mult_w", w_out, 2'b00);
    rtype(F_MFHI, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 5'd0);
    chk("dis_mfhi_stall", stall_o, 1'b0);
    step();
    chk("dis_mfhi_res", alu_out, 32'd0);
    chk("dis_mfhi_w", w_out, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
